// File: rtl/ddr4_axi_rd_cmd_gen_if.sv
// AXI read-address channel, read-command arbiter port and read-descriptor push
// bundled for the DDR4 AXI read command generator.
interface ddr4_axi_rd_cmd_gen_if #(
   parameter int C_AXI_ID_WIDTH   = 4,
   parameter int C_AXI_ADDR_WIDTH = 32,
   parameter int C_MC_ADDR_WIDTH  = 30
);
   // AXI AR channel
   logic [C_AXI_ID_WIDTH-1:0]   arid;
   logic [C_AXI_ADDR_WIDTH-1:0] araddr;
   logic [7:0]                  arlen;
   logic [2:0]                  arsize;
   logic [1:0]                  arburst;
   logic                        arvalid;
   logic                        arready;
   // Read commands toward the read/write command arbiter
   logic                        rd_cmd_en;
   logic                        rd_cmd_en_last;
   logic [2:0]                  rd_cmd_instr;
   logic [C_MC_ADDR_WIDTH-1:0]  rd_cmd_byte_addr;
   logic                        rd_cmd_full;
   // Per-transaction descriptor toward the read-data return path
   logic                        r_info_valid;
   logic [C_AXI_ID_WIDTH-1:0]   r_info_id;
   logic [9:0]                  r_info_cnt;
   logic                        r_info_full;

   modport slave (
      input  arid, araddr, arlen, arsize, arburst, arvalid, rd_cmd_full, r_info_full,
      output arready, rd_cmd_en, rd_cmd_en_last, rd_cmd_instr, rd_cmd_byte_addr,
             r_info_valid, r_info_id, r_info_cnt
   );

   modport master (
      output arid, araddr, arlen, arsize, arburst, arvalid, rd_cmd_full, r_info_full,
      input  arready, rd_cmd_en, rd_cmd_en_last, rd_cmd_instr, rd_cmd_byte_addr,
             r_info_valid, r_info_id, r_info_cnt
   );
endinterface

// File: rtl/ddr4_axi_rd_cmd_gen.sv
// Read-address front end of the DDR4 AXI slave: accepts one AR transaction at a
// time, splits it into one memory-controller command per C_MC_CMD_BYTES block
// touched, and pushes a per-transaction descriptor to the read-data path.
// Optional macro DDR4_AXI_RD_CMD_PREFETCH_EN lets the next AR be accepted on the
// final command handshake, skipping the IDLE bubble.
module ddr4_axi_rd_cmd_gen #(
   parameter int C_AXI_ID_WIDTH   = 4,
   parameter int C_AXI_ADDR_WIDTH = 32,
   parameter int C_MC_ADDR_WIDTH  = 30,
   parameter int C_AXI_DATA_WIDTH = 128,
   parameter int C_MC_CMD_BYTES   = 64
) (
   input  logic                 clk,
   input  logic                 reset,
   ddr4_axi_rd_cmd_gen_if.slave bus
);

   localparam int B        = $clog2(C_MC_CMD_BYTES);
   localparam int XW       = C_AXI_ADDR_WIDTH + 1;   // one spare bit so end-address math cannot overflow
   localparam int BLK_W    = XW - B;
   localparam logic [2:0] MAX_SIZE = 3'($clog2(C_AXI_DATA_WIDTH / 8));

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] CALC  = 2'd1;
   localparam logic [1:0] ISSUE = 2'd2;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   logic [1:0]                  state_q, state_d;
   logic [C_AXI_ID_WIDTH-1:0]   id_q, id_d;
   logic [C_AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [7:0]                  len_q, len_d;
   logic [2:0]                  size_q, size_d;
   logic [1:0]                  burst_q, burst_d;
   logic [BLK_W-1:0]            blk_q, blk_d;
   logic [9:0]                  rem_q, rem_d;
   logic [BLK_W-1:0]            wlo_q, wlo_d;
   logic [BLK_W-1:0]            whi_q, whi_d;

   logic [XW-1:0]    addr_x, sz_x, alg_x, span_x, end_x, wbase_x, wlast_x;
   logic [2:0]       size_eff;
   logic [9:0]       n_m1;
   logic             ar_take, cmd_take;

   // Command count and wrap window of the registered AR, evaluated during CALC
   always_comb begin
      size_eff = (size_q > MAX_SIZE) ? MAX_SIZE : size_q;
      addr_x   = {1'b0, addr_q};
      sz_x     = XW'(1) << size_eff;
      span_x   = XW'({1'b0, len_q} + 9'd1) << size_eff;
      alg_x    = addr_x & ~(sz_x - XW'(1));
      end_x    = alg_x + span_x - XW'(1);
      wbase_x  = addr_x & ~(span_x - XW'(1));
      wlast_x  = wbase_x + span_x - XW'(1);
      case (burst_q)
         BURST_FIXED: n_m1 = {2'b00, len_q};
         BURST_WRAP:  n_m1 = (span_x <= XW'(C_MC_CMD_BYTES)) ? 10'd0
                                                             : 10'((span_x >> B) - XW'(1));
         default:     n_m1 = 10'((end_x >> B) - (addr_x >> B));
      endcase
   end

   // AR acceptance: only in IDLE, and never while reset is being applied
   always_comb begin
      bus.arready = 1'b0;
      if (!reset) begin
         if (state_q == IDLE) begin
            bus.arready = ~bus.r_info_full;
         end
`ifdef DDR4_AXI_RD_CMD_PREFETCH_EN
         else if (state_q == ISSUE) begin
            bus.arready = bus.rd_cmd_en_last & ~bus.rd_cmd_full & ~bus.r_info_full;
         end
`endif
      end
   end

   // Command and descriptor outputs decoded from the registered state
   always_comb begin
      bus.rd_cmd_en        = (state_q == ISSUE);
      bus.rd_cmd_en_last   = (state_q == ISSUE) && (rem_q == 10'd0);
      bus.rd_cmd_instr     = 3'b001;
      bus.rd_cmd_byte_addr = (state_q == ISSUE) ? C_MC_ADDR_WIDTH'({blk_q, {B{1'b0}}}) : '0;
      bus.r_info_valid     = (state_q == CALC);
      bus.r_info_id        = (state_q == CALC) ? id_q : '0;
      bus.r_info_cnt       = (state_q == CALC) ? n_m1 : 10'd0;
   end

   assign ar_take  = bus.arvalid & bus.arready;
   assign cmd_take = bus.rd_cmd_en & ~bus.rd_cmd_full;

   // Next-state: capture AR, set up the command walk, step it on each handshake
   always_comb begin
      // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
      state_d = state_q;
      id_d    = id_q;
      addr_d  = addr_q;
      len_d   = len_q;
      size_d  = size_q;
      burst_d = burst_q;
      blk_d   = blk_q;
      rem_d   = rem_q;
      wlo_d   = wlo_q;
      whi_d   = whi_q;

      if (ar_take) begin
         id_d    = bus.arid;
         addr_d  = bus.araddr;
         len_d   = bus.arlen;
         size_d  = bus.arsize;
         burst_d = bus.arburst;
      end

      case (state_q)
         IDLE: begin
            if (ar_take) state_d = CALC;
         end
         CALC: begin
            state_d = ISSUE;
            blk_d   = BLK_W'(addr_x >> B);
            rem_d   = n_m1;
            wlo_d   = BLK_W'(wbase_x >> B);
            whi_d   = BLK_W'(wlast_x >> B);
         end
         ISSUE: begin
            if (cmd_take) begin
               if (rem_q == 10'd0) begin
                  state_d = ar_take ? CALC : IDLE;
               end else begin
                  rem_d = rem_q - 10'd1;
                  case (burst_q)
                     BURST_FIXED: blk_d = blk_q;
                     BURST_WRAP:  blk_d = (blk_q == whi_q) ? wlo_q : blk_q + BLK_W'(1);
                     default:     blk_d = blk_q + BLK_W'(1);
                  endcase
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers; reset abandons any transaction in flight
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
      if (reset) begin
         state_q <= IDLE;
         id_q    <= '0;
         addr_q  <= '0;
         len_q   <= '0;
         size_q  <= '0;
         burst_q <= '0;
         blk_q   <= '0;
         rem_q   <= '0;
         wlo_q   <= '0;
         whi_q   <= '0;
      end else begin
         state_q <= state_d;
         id_q    <= id_d;
         addr_q  <= addr_d;
         len_q   <= len_d;
         size_q  <= size_d;
         burst_q <= burst_d;
         blk_q   <= blk_d;
         rem_q   <= rem_d;
         wlo_q   <= wlo_d;
         whi_q   <= whi_d;
      end
   end

endmodule

// File: tb/tb_ddr4_axi_rd_cmd_gen.sv
// Directed bench for ddr4_axi_rd_cmd_gen (128-bit AXI, 64-byte MC commands).
module tb_ddr4_axi_rd_cmd_gen;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;

   ddr4_axi_rd_cmd_gen_if #(.C_AXI_ID_WIDTH(4), .C_AXI_ADDR_WIDTH(32), .C_MC_ADDR_WIDTH(30)) bus ();

   ddr4_axi_rd_cmd_gen #(
      .C_AXI_ID_WIDTH(4), .C_AXI_ADDR_WIDTH(32), .C_MC_ADDR_WIDTH(30),
      .C_AXI_DATA_WIDTH(128), .C_MC_CMD_BYTES(64)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Present an AR and wait (bounded) until it is accepted; returns after the handshake edge.
   task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, output bit accepted);
      int waited;
      waited = 0;
      @(negedge clk);
      bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arsize = size; bus.arburst = burst;
      bus.arvalid = 1'b1;
      #1;
      while (bus.arready !== 1'b1 && waited < 20) begin
         @(negedge clk); #1; waited++;
      end
      accepted = (bus.arready === 1'b1);
      if (accepted) begin
         @(posedge clk); #1;
      end
      bus.arvalid = 1'b0;
   endtask

   // One complete transaction with no back-pressure: descriptor, then n commands.
   task automatic run_txn(input string name, input logic [3:0] id, input logic [31:0] addr,
                          input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst,
                          input logic [9:0] exp_cnt, input int n,
                          input logic [29:0] a0, input logic [29:0] a1,
                          input logic [29:0] a2, input logic [29:0] a3);
      bit ok;
      logic [29:0] exp_a [4];
      exp_a[0] = a0; exp_a[1] = a1; exp_a[2] = a2; exp_a[3] = a3;
      send_ar(id, addr, len, size, burst, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL %s ar_accept: arready never rose, want 1", name); end
      else begin
         @(negedge clk);
         n_checks++;
         if (bus.r_info_valid !== 1'b1 || bus.r_info_cnt !== exp_cnt || bus.r_info_id !== id ||
             bus.rd_cmd_en !== 1'b0 || bus.arready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s info: valid=%b cnt=%0d id=%0d en=%b arready=%b, want 1 %0d %0d 0 0",
                     name, bus.r_info_valid, bus.r_info_cnt, bus.r_info_id, bus.rd_cmd_en,
                     bus.arready, exp_cnt, id);
         end
         for (int i = 0; i < n; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus.rd_cmd_en !== 1'b1 || bus.rd_cmd_byte_addr !== exp_a[i] ||
                bus.rd_cmd_en_last !== (i == n - 1) || bus.rd_cmd_instr !== 3'b001 ||
                bus.r_info_valid !== 1'b0) begin
               n_fail++;
               $display("FAIL %s cmd%0d: en=%b addr=%h last=%b instr=%b info=%b, want 1 %h %b 001 0",
                        name, i, bus.rd_cmd_en, bus.rd_cmd_byte_addr, bus.rd_cmd_en_last,
                        bus.rd_cmd_instr, bus.r_info_valid, exp_a[i], (i == n - 1));
            end
         end
         @(negedge clk);
         n_checks++;
         if (bus.rd_cmd_en !== 1'b0 || bus.arready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s done: en=%b arready=%b, want 0 1", name, bus.rd_cmd_en, bus.arready);
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (bus.arready !== 1'b0 || bus.rd_cmd_en !== 1'b0 || bus.rd_cmd_en_last !== 1'b0 ||
          bus.r_info_valid !== 1'b0 || bus.rd_cmd_byte_addr !== 30'd0 ||
          bus.r_info_id !== 4'd0 || bus.r_info_cnt !== 10'd0) begin
         n_fail++;
         $display("FAIL reset_values: arready=%b en=%b last=%b iv=%b addr=%h id=%0d cnt=%0d, want all 0",
                  bus.arready, bus.rd_cmd_en, bus.rd_cmd_en_last, bus.r_info_valid,
                  bus.rd_cmd_byte_addr, bus.r_info_id, bus.r_info_cnt);
      end
      reset = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bus.arready !== 1'b1 || bus.rd_cmd_en !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_idle: arready=%b en=%b, want 1 0", bus.arready, bus.rd_cmd_en);
      end
   endtask

   task automatic test_incr();
      run_txn("incr_aligned", 4'd3, 32'h1000, 8'd7, 3'd4, 2'b01, 10'd1, 2,
              30'h1000, 30'h1040, 30'h0, 30'h0);
      run_txn("incr_unaligned", 4'd5, 32'h1030, 8'd3, 3'd4, 2'b01, 10'd1, 2,
              30'h1000, 30'h1040, 30'h0, 30'h0);
      run_txn("incr_burst11", 4'd6, 32'h1000, 8'd3, 3'd4, 2'b11, 10'd0, 1,
              30'h1000, 30'h0, 30'h0, 30'h0);
   endtask

   task automatic test_wrap();
      run_txn("wrap_two_blocks", 4'd9, 32'h2070, 8'd7, 3'd4, 2'b10, 10'd1, 2,
              30'h2040, 30'h2000, 30'h0, 30'h0);
      run_txn("wrap_one_block", 4'd10, 32'h2030, 8'd3, 3'd4, 2'b10, 10'd0, 1,
              30'h2000, 30'h0, 30'h0, 30'h0);
   endtask

   task automatic test_fixed();
      run_txn("fixed", 4'd12, 32'h3010, 8'd2, 3'd4, 2'b00, 10'd2, 3,
              30'h3000, 30'h3000, 30'h3000, 30'h0);
   endtask

   // Back-pressure on the 2nd command, then reset during the 3rd.
   task automatic test_stall_and_reset();
      bit ok;
      send_ar(4'd7, 32'h1000, 8'd15, 3'd4, 2'b01, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL stall ar_accept: arready never rose, want 1"); end
      else begin
         @(negedge clk);
         n_checks++;
         if (bus.r_info_valid !== 1'b1 || bus.r_info_cnt !== 10'd3 || bus.r_info_id !== 4'd7) begin
            n_fail++;
            $display("FAIL stall info: valid=%b cnt=%0d id=%0d, want 1 3 7",
                     bus.r_info_valid, bus.r_info_cnt, bus.r_info_id);
         end
         @(negedge clk);
         n_checks++;
         if (bus.rd_cmd_en !== 1'b1 || bus.rd_cmd_byte_addr !== 30'h1000 || bus.rd_cmd_en_last !== 1'b0) begin
            n_fail++;
            $display("FAIL stall cmd0: en=%b addr=%h last=%b, want 1 1000 0",
                     bus.rd_cmd_en, bus.rd_cmd_byte_addr, bus.rd_cmd_en_last);
         end
         @(negedge clk);
         n_checks++;
         if (bus.rd_cmd_en !== 1'b1 || bus.rd_cmd_byte_addr !== 30'h1040) begin
            n_fail++;
            $display("FAIL stall cmd1: en=%b addr=%h, want 1 1040", bus.rd_cmd_en, bus.rd_cmd_byte_addr);
         end
         bus.rd_cmd_full = 1'b1;
         for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++;
            if (bus.rd_cmd_en !== 1'b1 || bus.rd_cmd_byte_addr !== 30'h1040 ||
                bus.rd_cmd_en_last !== 1'b0 || bus.arready !== 1'b0) begin
               n_fail++;
               $display("FAIL stall hold%0d: en=%b addr=%h last=%b arready=%b, want 1 1040 0 0",
                        k, bus.rd_cmd_en, bus.rd_cmd_byte_addr, bus.rd_cmd_en_last, bus.arready);
            end
         end
         bus.rd_cmd_full = 1'b0;
         @(negedge clk);
         n_checks++;
         if (bus.rd_cmd_en !== 1'b1 || bus.rd_cmd_byte_addr !== 30'h1080 || bus.rd_cmd_en_last !== 1'b0) begin
            n_fail++;
            $display("FAIL stall cmd2: en=%b addr=%h last=%b, want 1 1080 0",
                     bus.rd_cmd_en, bus.rd_cmd_byte_addr, bus.rd_cmd_en_last);
         end
         reset = 1'b1;
         @(negedge clk);
         n_checks++;
         if (bus.rd_cmd_en !== 1'b0 || bus.rd_cmd_en_last !== 1'b0 || bus.rd_cmd_byte_addr !== 30'd0 ||
             bus.r_info_valid !== 1'b0 || bus.r_info_cnt !== 10'd0 || bus.r_info_id !== 4'd0 ||
             bus.arready !== 1'b0) begin
            n_fail++;
            $display("FAIL midburst_reset: en=%b last=%b addr=%h iv=%b cnt=%0d id=%0d arready=%b, want all 0",
                     bus.rd_cmd_en, bus.rd_cmd_en_last, bus.rd_cmd_byte_addr, bus.r_info_valid,
                     bus.r_info_cnt, bus.r_info_id, bus.arready);
         end
         reset = 1'b0;
         @(negedge clk);
         n_checks++;
         if (bus.arready !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_arready: got %b, want 1", bus.arready);
         end
         for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_checks++;
            if (bus.rd_cmd_en !== 1'b0 || bus.r_info_valid !== 1'b0) begin
               n_fail++;
               $display("FAIL abandoned%0d: en=%b iv=%b, want 0 0", k, bus.rd_cmd_en, bus.r_info_valid);
            end
         end
      end
   endtask

   // Descriptor FIFO full holds off AR acceptance in IDLE.
   task automatic test_info_full();
      @(negedge clk);
      bus.r_info_full = 1'b1;
      bus.arid = 4'd2; bus.araddr = 32'h1000; bus.arlen = 8'd0; bus.arsize = 3'd4; bus.arburst = 2'b01;
      bus.arvalid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_checks++;
         if (bus.arready !== 1'b0 || bus.r_info_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL info_full_block%0d: arready=%b iv=%b, want 0 0", k, bus.arready, bus.r_info_valid);
         end
      end
      bus.r_info_full = 1'b0;
      #1;
      n_checks++;
      if (bus.arready !== 1'b1) begin
         n_fail++;
         $display("FAIL info_full_release: arready=%b, want 1", bus.arready);
      end
      @(posedge clk); #1;
      bus.arvalid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bus.r_info_valid !== 1'b1 || bus.r_info_cnt !== 10'd0 || bus.r_info_id !== 4'd2) begin
         n_fail++;
         $display("FAIL info_full_desc: valid=%b cnt=%0d id=%0d, want 1 0 2",
                  bus.r_info_valid, bus.r_info_cnt, bus.r_info_id);
      end
      @(negedge clk);
      n_checks++;
      if (bus.rd_cmd_en !== 1'b1 || bus.rd_cmd_byte_addr !== 30'h1000 || bus.rd_cmd_en_last !== 1'b1) begin
         n_fail++;
         $display("FAIL info_full_cmd: en=%b addr=%h last=%b, want 1 1000 1",
                  bus.rd_cmd_en, bus.rd_cmd_byte_addr, bus.rd_cmd_en_last);
      end
      @(negedge clk);
      n_checks++;
      if (bus.rd_cmd_en !== 1'b0) begin
         n_fail++;
         $display("FAIL info_full_done: en=%b, want 0", bus.rd_cmd_en);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      reset    = 1'b1;
      bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0;
      bus.arvalid = 1'b0; bus.rd_cmd_full = 1'b0; bus.r_info_full = 1'b0;

      test_reset();
      test_incr();
      test_wrap();
      test_fixed();
      test_stall_and_reset();
      test_info_full();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ddr4_axi_rd_cmd_gen.md
Name: ddr4_axi_rd_cmd_gen

Overview:
- Read-address front end of the AXI slave. Accepts one AXI AR transaction at a time.
- Splits the transaction into memory-controller commands, one per C_MC_CMD_BYTES-aligned block touched.
- Drives the read-command inputs of the read/write command arbiter (rd_cmd_en, rd_cmd_en_last, rd_cmd_instr, rd_cmd_byte_addr) and honours its rd_cmd_full back-pressure.
- Pushes a per-transaction descriptor to the read-data return path.

Parameters:
- C_AXI_ID_WIDTH, 4, width of arid.
- C_AXI_ADDR_WIDTH, 32, width of araddr.
- C_MC_ADDR_WIDTH, 30, width of rd_cmd_byte_addr; the low bits of the block address are kept.
- C_AXI_DATA_WIDTH, 128, AXI data width in bits; legal arsize is at most log2(C_AXI_DATA_WIDTH/8).
- C_MC_CMD_BYTES, 64, bytes covered by one MC command; power of two, at least C_AXI_DATA_WIDTH/8.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- arid  in  C_AXI_ID_WIDTH  transaction ID
- araddr  in  C_AXI_ADDR_WIDTH  start byte address
- arlen  in  8  beats minus 1
- arsize  in  3  log2 of bytes per beat
- arburst  in  2  00 FIXED, 01 INCR, 10 WRAP (11 treated as INCR)
- arvalid  in  1  AR valid
- arready  out  1  AR ready
- rd_cmd_en  out  1  command valid toward the arbiter
- rd_cmd_en_last  out  1  final command of the current transaction
- rd_cmd_instr  out  3  constant 3'b001 (read)
- rd_cmd_byte_addr  out  C_MC_ADDR_WIDTH  block-aligned command address
- rd_cmd_full  in  1  arbiter cannot take a command this cycle
- r_info_valid  out  1  descriptor push, one-cycle pulse
- r_info_id  out  C_AXI_ID_WIDTH  arid of the pushed transaction
- r_info_cnt  out  10  number of commands minus 1
- r_info_full  in  1  descriptor FIFO full

Behaviour:
- Reset values: arready=0, rd_cmd_en=0, rd_cmd_en_last=0, r_info_valid=0, rd_cmd_byte_addr=0, r_info_id=0, r_info_cnt=0; state=IDLE.
- Reset asserted mid-burst abandons the transaction. No further commands issue for it and no descriptor is pushed for it.
- Command handshake: a command is taken when rd_cmd_en & ~rd_cmd_full. While stalled, rd_cmd_en, rd_cmd_en_last and rd_cmd_byte_addr hold stable.

State machine IDLE -> CALC -> ISSUE -> IDLE:
- IDLE:
  - arready = ~r_info_full.
  - On arvalid & arready, register the AR fields and go to CALC.
- CALC (one cycle, all outputs quiet):
  - B = log2(C_MC_CMD_BYTES); S = 1<<arsize; a = araddr aligned down to S.
  - INCR: N = ((a + (arlen+1)*S - 1) >> B) - (araddr >> B) + 1. First block = araddr >> B; step +1 block.
  - WRAP: window W = (arlen+1)*S, wbase = araddr aligned down to W.
    - If W <= C_MC_CMD_BYTES: N = 1, block = araddr >> B.
    - Else: N = W / C_MC_CMD_BYTES; start block = araddr >> B; step +1 block, wrapping to wbase>>B after (wbase+W-1)>>B.
  - FIXED: N = arlen+1; every command uses block araddr >> B.
  - Compute arithmetic in at least C_AXI_ADDR_WIDTH+1 bits so there is no overflow.
  - Pulse r_info_valid=1 with r_info_cnt=N-1 and r_info_id=arid. r_info_full is already guaranteed low by the IDLE accept rule.
  - Go to ISSUE.
- ISSUE:
  - rd_cmd_en=1; rd_cmd_byte_addr = block << B, truncated to C_MC_ADDR_WIDTH.
  - The remaining-count register counts down on each handshake. rd_cmd_en_last=1 when remaining = 0.
  - The handshake on the last command returns to IDLE.
- Latency: AR handshake at cycle T -> r_info_valid at T+1 -> first rd_cmd_en at T+2. Minimum gap between successive AR accepts is N+2 cycles.
- arready is never 1 outside IDLE (unless the optional feature is enabled).

Optional Feature:
DDR4_AXI_RD_CMD_PREFETCH_EN
- Defined: in ISSUE, arready = rd_cmd_en_last & ~rd_cmd_full & ~r_info_full. An AR accepted in that cycle goes directly to CALC, removing the IDLE bubble; the minimum accept gap becomes N+1.
- Undefined: behaviour exactly as above.

Test Plan (C_AXI_DATA_WIDTH=128, C_MC_CMD_BYTES=64):
- INCR araddr=0x1000, arlen=7, arsize=4 -> r_info_cnt=1; commands 0x1000, then 0x1040 with last=1; first rd_cmd_en 2 cycles after the AR handshake.
- INCR araddr=0x1030, arlen=3, arsize=4 -> commands 0x1000, 0x1040 (last).
- WRAP araddr=0x2070, arlen=7, arsize=4 -> commands 0x2040, 0x2000 (last).
- WRAP araddr=0x2030, arlen=3, arsize=4 -> a single command 0x2000 with last=1.
- FIXED araddr=0x3010, arlen=2 -> three commands at 0x3000, last on the third.
- INCR araddr=0x1000, arlen=15, arsize=4 (4 commands):
  - rd_cmd_full=1 for 3 cycles during the 2nd command -> 0x1040 held, no command skipped.
  - Assert reset during the 3rd command -> next cycle all outputs are 0 and arready=0; after reset, arready returns to 1 in IDLE.
  - With r_info_full=1 in IDLE -> arready stays 0 until r_info_full drops.
